imme_gen_pipe: RTL and testbench

Parametrised, registered immediate generator for the decode stage. Covers all RV base formats (I, S, B, U, J, shift-amount) at XLEN 32 or 64. Carries the PC alongside the immediate. Sits between fetch and execute behind a valid/ready skid buffer, so decode runs at full throughput and absorbs execute-side stalls without losing instructions.

---
 rtl/imme_gen_pipe.sv | 173 +++++++++++++++++
 tb/tb_imme_gen_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imme_gen_pipe.sv
// imme_gen_pipe: registered RV immediate generator with a two-entry
// valid/ready skid buffer (main entry drives outputs, skid absorbs stalls).
// Optional macro IMME_ILLEGAL_CHK_EN adds o_illegal and encoding checks.
module imme_gen_pipe #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instruction,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_imme_value,
  output logic [2:0]      o_imme_fmt,
`ifdef IMME_ILLEGAL_CHK_EN
  output logic            o_illegal,
`endif
  output logic [XLEN-1:0] o_pc
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

  typedef struct packed {
`ifdef IMME_ILLEGAL_CHK_EN
    logic            ill;
`endif
    logic [2:0]      fmt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] val;
  } entry_t;

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  state_e state_q, state_d;
  logic   ready_q, ready_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t dec;
  logic   accept, xfer;

  logic [31:0] ins;
  assign ins = i_instruction;

  // Decode the incoming word so stored entries already hold final values.
  always_comb begin
    dec        = '0;
    dec.pc     = i_pc;
`ifdef IMME_ILLEGAL_CHK_EN
    dec.ill    = (ins[1:0] != 2'b11);
`endif
    case (ins[6:0])
      7'b0000011, 7'b1100111, 7'b1110011: begin
        dec.fmt = FMT_I;
        dec.val = XLEN'($signed(ins[31:20]));
      end
      7'b0010011: begin
        if (ins[13:12] == 2'b01) begin
          dec.fmt = FMT_SHAMT;
          if (XLEN == 64) dec.val[5:0] = ins[25:20];
          else            dec.val[4:0] = ins[24:20];
`ifdef IMME_ILLEGAL_CHK_EN
          if (XLEN == 64)
            dec.ill = !((ins[31:26] == 6'b000000) || (ins[31:26] == 6'b010000));
          else
            dec.ill = !((ins[31:25] == 7'b0000000) || (ins[31:25] == 7'b0100000));
`endif
        end else begin
          dec.fmt = FMT_I;
          dec.val = XLEN'($signed(ins[31:20]));
        end
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        dec.val = XLEN'($signed({ins[31:25], ins[11:7]}));
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        dec.val = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        dec.val = XLEN'($signed({ins[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        dec.val = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      default: begin
        dec.fmt = FMT_NONE;
`ifdef IMME_ILLEGAL_CHK_EN
        dec.ill = 1'b1;
`endif
      end
    endcase
`ifdef IMME_ILLEGAL_CHK_EN
    if (dec.ill) begin
      dec.fmt = FMT_NONE;
      dec.val = '0;
    end
`endif
  end

  // Skid-buffer occupancy and entry movement; flush overrides everything.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    accept  = i_valid & ready_q;
    xfer    = (state_q != ST_EMPTY) & i_ready;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = dec;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (xfer && accept) begin
          main_d = dec;
        end else if (xfer) begin
          state_d = ST_EMPTY;
        end else if (accept) begin
          skid_d  = dec;
          state_d = ST_TWO;
        end
      end
      ST_TWO: begin
        if (xfer) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (i_flush) state_d = ST_EMPTY;
    // Ready is registered: it is a function of the next occupancy only.
    ready_d = (state_d != ST_TWO);
  end

  // State, ready flag and both entries.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_valid      = (state_q != ST_EMPTY);
  assign o_imme_value = main_q.val;
  assign o_imme_fmt   = main_q.fmt;
  assign o_pc         = main_q.pc;
`ifdef IMME_ILLEGAL_CHK_EN
  assign o_illegal    = main_q.ill;
`endif

endmodule

// File: tb/tb_imme_gen_pipe.sv
// Testbench for imme_gen_pipe (XLEN=32 scoreboarded instance plus an
// XLEN=64 instance for wide shift/sign-extension cases).
module tb_imme_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        out_valid;
  logic        dn_ready;
  logic [31:0] imm;
  logic [2:0]  fmt;
  logic [31:0] opc;
`ifdef IMME_ILLEGAL_CHK_EN
  logic        ill;
  logic        ill64;
`endif

  logic        v64;
  logic        rdy64;
  logic [31:0] instr64;
  logic [63:0] pc64;
  logic        ov64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [63:0] opc64;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  imme_gen_pipe #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid),
    .o_ready(out_ready), .i_instruction(instr), .i_pc(pc), .o_valid(out_valid),
    .i_ready(dn_ready), .o_imme_value(imm), .o_imme_fmt(fmt),
`ifdef IMME_ILLEGAL_CHK_EN
    .o_illegal(ill),
`endif
    .o_pc(opc)
  );

  imme_gen_pipe #(.XLEN(64)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(1'b0), .i_valid(v64),
    .o_ready(rdy64), .i_instruction(instr64), .i_pc(pc64), .o_valid(ov64),
    .i_ready(1'b1), .o_imme_value(imm64), .o_imme_fmt(fmt64),
`ifdef IMME_ILLEGAL_CHK_EN
    .o_illegal(ill64),
`endif
    .o_pc(opc64)
  );

  typedef struct {
    logic [31:0] v;
    logic [2:0]  f;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  exp_t sbq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w, input logic [31:0] p);
    exp_t e;
    e.v = 32'd0; e.f = 3'd0; e.pc = p; e.ill = 1'b0;
    case (w[6:0])
      7'h03, 7'h67, 7'h73: begin e.f = 3'd1; e.v = {{20{w[31]}}, w[31:20]}; end
      7'h13: begin
        if (w[13:12] == 2'b01) begin
          e.f = 3'd6; e.v = {27'd0, w[24:20]};
          e.ill = !((w[31:25] == 7'h00) || (w[31:25] == 7'h20));
        end else begin
          e.f = 3'd1; e.v = {{20{w[31]}}, w[31:20]};
        end
      end
      7'h23: begin e.f = 3'd2; e.v = {{20{w[31]}}, w[31:25], w[11:7]}; end
      7'h63: begin e.f = 3'd3; e.v = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0}; end
      7'h37, 7'h17: begin e.f = 3'd4; e.v = {w[31:12], 12'd0}; end
      7'h6F: begin e.f = 3'd5; e.v = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0}; end
      default: e.ill = 1'b1;
    endcase
`ifdef IMME_ILLEGAL_CHK_EN
    if (e.ill) begin e.f = 3'd0; e.v = 32'd0; end
`else
    e.ill = 1'b0;
`endif
    return e;
  endfunction

  // Scoreboard: push on accept, pop/compare on transfer, clear on flush/reset.
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
    end else begin
      if (out_valid && dn_ready && !flush) begin
        if (sbq.size() == 0) begin
          check("sb_unexpected_output", {32'd0, opc}, 64'hDEAD);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("sb_value", {32'd0, imm}, {32'd0, e.v});
          check("sb_fmt", {61'd0, fmt}, {61'd0, e.f});
          check("sb_pc", {32'd0, opc}, {32'd0, e.pc});
`ifdef IMME_ILLEGAL_CHK_EN
          check("sb_illegal", {63'd0, ill}, {63'd0, e.ill});
`endif
        end
      end
      if (flush) sbq.delete();
      else if (in_valid && out_ready) sbq.push_back(model(instr, pc));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] w;
    logic [31:0] v;
    logic [2:0]  f;
  } vec_t;

  vec_t tab[8];

  initial begin
    tab[0] = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1};
    tab[1] = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3};
    tab[2] = '{32'h123452B7, 32'h12345000, 3'd4};
    tab[3] = '{32'h0080006F, 32'h00000008, 3'd5};
    tab[4] = '{32'h00309093, 32'h00000003, 3'd6};
    tab[5] = '{32'h4030D093, 32'h00000003, 3'd6};
    tab[6] = '{32'h00112623, 32'h0000000C, 3'd2};
    tab[7] = '{32'h00000033, 32'h00000000, 3'd0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; dn_ready = 1'b1;
    v64 = 1'b0; instr64 = '0; pc64 = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_ready", {63'd0, out_ready}, 64'd1);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_value", {32'd0, imm}, 64'd0);

    // Back-to-back, full throughput, one-cycle latency.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; instr = tab[i].w; pc = 32'h1000 + 32'(4 * i);
      tick();
      check("lat_valid", {63'd0, out_valid}, 64'd1);
      check("tab_value", {32'd0, imm}, {32'd0, tab[i].v});
      check("tab_fmt", {61'd0, fmt}, {61'd0, tab[i].f});
      check("tab_pc", {32'd0, opc}, {32'd0, 32'h1000 + 32'(4 * i)});
    end
    in_valid = 1'b0;
    tick();
    check("idle_valid", {63'd0, out_valid}, 64'd0);

`ifdef IMME_ILLEGAL_CHK_EN
    in_valid = 1'b1; instr = 32'h0000007F; pc = 32'h2000;
    tick();
    check("ill_opc", {63'd0, ill}, 64'd1);
    check("ill_opc_fmt", {61'd0, fmt}, 64'd0);
    check("ill_opc_val", {32'd0, imm}, 64'd0);
    instr = 32'h2030D093;
    tick();
    check("ill_shift", {63'd0, ill}, 64'd1);
    instr = 32'h4030D093;
    tick();
    check("legal_srai", {63'd0, ill}, 64'd0);
    in_valid = 1'b0;
    tick();
`endif

    // XLEN=64 instance.
    v64 = 1'b1; instr64 = 32'h03F09093; pc64 = 64'h0000_0001_0000_0004;
    tick();
    check("x64_shamt", imm64, 64'd63);
    check("x64_shamt_fmt", {61'd0, fmt64}, 64'd6);
    check("x64_pc", opc64, 64'h0000_0001_0000_0004);
    instr64 = 32'hFFF00093;
    tick();
    check("x64_sext", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    v64 = 1'b0;
    tick();
    check("x64_idle", {63'd0, ov64}, 64'd0);

    // Backpressure: three offers while downstream stalls.
    dn_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h00500093; pc = 32'h3000;
    tick();
    check("bp_a_ready", {63'd0, out_ready}, 64'd1);
    check("bp_a_value", {32'd0, imm}, 64'd5);
    instr = 32'h00A00113; pc = 32'h3004;
    tick();
    check("bp_full_ready", {63'd0, out_ready}, 64'd0);
    check("bp_hold_value", {32'd0, imm}, 64'd5);
    instr = 32'h00F00193; pc = 32'h3008;
    tick();
    check("bp_still_full", {63'd0, out_ready}, 64'd0);
    check("bp_hold_pc", {32'd0, opc}, 64'h3000);
    dn_ready = 1'b1;
    tick();
    check("bp_drain_b", {32'd0, imm}, 64'd10);
    check("bp_ready_back", {63'd0, out_ready}, 64'd1);
    tick();
    check("bp_drain_c", {32'd0, imm}, 64'd15);
    in_valid = 1'b0;
    tick();
    check("bp_empty", {63'd0, out_valid}, 64'd0);

    // Flush while full, with an instruction offered.
    dn_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h01400093; pc = 32'h4000;
    tick();
    instr = 32'h01900093; pc = 32'h4004;
    tick();
    check("fl_two_ready", {63'd0, out_ready}, 64'd0);
    instr = 32'h7FF00093; pc = 32'h4008; flush = 1'b1;
    tick();
    check("fl_two_valid", {63'd0, out_valid}, 64'd0);
    check("fl_two_ready1", {63'd0, out_ready}, 64'd1);
    // Flush in ONE while an accept happens: accepted word is dropped.
    flush = 1'b0; instr = 32'h02300093; pc = 32'h400C;
    tick();
    instr = 32'h02D00093; pc = 32'h4010; flush = 1'b1;
    tick();
    check("fl_one_valid", {63'd0, out_valid}, 64'd0);
    flush = 1'b0; in_valid = 1'b0; dn_ready = 1'b1;
    tick(); tick();
    check("fl_no_ghost", {63'd0, out_valid}, 64'd0);
    check("fl_ready", {63'd0, out_ready}, 64'd1);

    // Asynchronous reset while an output is stalled.
    dn_ready = 1'b0; in_valid = 1'b1; instr = 32'h12345037; pc = 32'h0ABC;
    tick();
    in_valid = 1'b0;
    check("rs_pre_valid", {63'd0, out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_valid", {63'd0, out_valid}, 64'd0);
    check("rs_value", {32'd0, imm}, 64'd0);
    check("rs_fmt", {61'd0, fmt}, 64'd0);
    check("rs_pc", {32'd0, opc}, 64'd0);
    tick();
    rst_n = 1'b1; dn_ready = 1'b1;
    tick();
    check("rs_ready", {63'd0, out_ready}, 64'd1);
    check("rs_idle", {63'd0, out_valid}, 64'd0);
    in_valid = 1'b1; instr = 32'hFFF00093; pc = 32'h5000;
    tick();
    check("rs_after_value", {32'd0, imm}, 64'hFFFFFFFF);
    in_valid = 1'b0;
    tick(); tick();
    check("sb_drained", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
